dmem_bank: RTL

DMEM_BANK -- requirements
Module: dmem_bank

---
 rtl/dmem_pkg.sv | 72 +++++++
 rtl/dmem_bank_if.sv | 27 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data memory bank.
// Holds access-size encoding, FSM states and byte-lane functions.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_R = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int CNT_W = 4;

   // Byte enables for an access; off is already
   // forced to the natural alignment of sz.
   function automatic logic [3:0] lane_be(
      input size_e      sz,
      input logic [1:0] off
   );
      logic [3:0] be;
      unique case (sz)
         SZ_B:    be = 4'b0001 << off;
         SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate right-aligned store data onto every
   // lane so the byte enables pick the right copy.
   function automatic logic [31:0] lane_wdata(
      input size_e       sz,
      input logic [31:0] wd
   );
      logic [31:0] r;
      unique case (sz)
         SZ_B:    r = {4{wd[7:0]}};
         SZ_H:    r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_ext(
      input size_e       sz,
      input logic [1:0]  off,
      input logic        usgn,
      input logic [31:0] w
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      unique case (sz)
         SZ_B: r = usgn ? {24'b0, b}
                        : {{24{b[7]}}, b};
         SZ_H: r = usgn ? {16'b0, h}
                        : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_bank_if.sv
// dmem_bank_if: request/response bundle of the data memory bank.
// master drives req/we/addr/size/usgn/wdata; slave returns ready/rvalid/rdata/err.
interface dmem_bank_if;
   import dmem_pkg::*;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        usgn;
   logic [31:0] wdata;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, size, usgn, wdata,
      input  ready, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, size, usgn, wdata,
      output ready, rvalid, rdata, err
   );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage, byte-enable write, registered read.
// Ports: clk, idx (word), wr_en/be/wdata, rd_en, rdata (valid after rd_en edge).
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] idx,
   input  logic          wr_en,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   input  logic          rd_en,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // No reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (rd_en) begin
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_bank.sv
// dmem_bank: fixed-latency data memory with byte/half/word access and sign extension.
// Ports: clk, rst (sync, active high), bus (dmem_bank_if.slave). Macro DMEM_MISALIGN_TRAP_EN traps misaligned half/word.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYC    = 2
) (
   input logic        clk,
   input logic        rst,
   dmem_bank_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_INIT =
      CNT_W'(WAIT_CYC);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   size_e       size_q, size_d;
   logic        usgn_q, usgn_d;
   logic [31:0] wdata_q, wdata_d;

   logic [1:0]  roff_q, roff_d;
   size_e       rsize_q, rsize_d;
   logic        rusgn_q, rusgn_d;
   logic        rzero_q, rzero_d;
   logic        err_q, err_d;

   logic        idle;
   logic        go_resp;
   logic        acc_we;
   logic [31:0] acc_addr;
   size_e       acc_size;
   logic        acc_usgn;
   logic [31:0] acc_wdata;
   logic [1:0]  acc_off;
   logic        misal;
   logic        fault;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        unused_hi;

   assign idle = (state_q == ST_IDLE);

   // With zero wait the access completes on the
   // accept edge, so it must come straight off the bus.
   assign acc_we    = idle ? bus.we : we_q;
   assign acc_addr  = idle ? bus.addr : addr_q;
   assign acc_size  = idle ? size_e'(bus.size)
                           : size_q;
   assign acc_usgn  = idle ? bus.usgn : usgn_q;
   assign acc_wdata = idle ? bus.wdata : wdata_q;

   assign unused_hi = ^acc_addr[31:AW+2];

   always_comb begin
      misal = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misal = (acc_size == SZ_H && acc_addr[0])
           || (acc_size == SZ_W
               && acc_addr[1:0] != 2'b00);
`endif
      fault = (acc_size == SZ_R) || misal;
      unique case (acc_size)
         SZ_B:    acc_off = acc_addr[1:0];
         SZ_H:    acc_off = {acc_addr[1], 1'b0};
         default: acc_off = 2'b00;
      endcase
   end

   // Memory commit/sample happens on the RESP entry
   // edge; an asserted rst on that edge aborts it.
   assign go_resp = !rst &&
      ((idle && bus.req && WAIT_CYC == 0) ||
       (state_q == ST_WAIT && cnt_q == 1));

   assign mem_we = go_resp && acc_we && !fault;
   assign mem_re = go_resp && !acc_we && !fault;

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .idx   (acc_addr[AW+1:2]),
      .wr_en (mem_we),
      .be    (lane_be(acc_size, acc_off)),
      .wdata (lane_wdata(acc_size, acc_wdata)),
      .rd_en (mem_re),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      size_d  = size_q;
      usgn_d  = usgn_q;
      wdata_d = wdata_q;
      roff_d  = roff_q;
      rsize_d = rsize_q;
      rusgn_d = rusgn_q;
      rzero_d = rzero_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               addr_d  = bus.addr;
               size_d  = size_e'(bus.size);
               usgn_d  = bus.usgn;
               wdata_d = bus.wdata;
               if (WAIT_CYC == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Response info only moves on RESP entry,
      // keeping rdata/err steady until the next one.
      if (go_resp) begin
         roff_d  = acc_off;
         rsize_d = acc_size;
         rusgn_d = acc_usgn;
         rzero_d = acc_we || fault;
         err_d   = fault;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= SZ_B;
         usgn_q  <= 1'b0;
         wdata_q <= '0;
         roff_q  <= 2'b00;
         rsize_q <= SZ_B;
         rusgn_q <= 1'b0;
         rzero_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         usgn_q  <= usgn_d;
         wdata_q <= wdata_d;
         roff_q  <= roff_d;
         rsize_q <= rsize_d;
         rusgn_q <= rusgn_d;
         rzero_q <= rzero_d;
         err_q   <= err_d;
      end
   end

   assign bus.ready  = idle;
   assign bus.rvalid = (state_q == ST_RESP);
   assign bus.err    = err_q;
   assign bus.rdata  = rzero_q ? 32'h0
      : load_ext(rsize_q, roff_q, rusgn_q,
                 mem_rdata);

endmodule
